seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised multi-cycle ALU, the next-generation execute unit for the datapath. It supports the same 13-opcode set and the {high, low} result packing used by the Z register. Operands are latched on a start handshake. Logic, shift and add ops finish in one cycle; signed multiply (radix-2 Booth) and signed divide (non-restoring) iterate one bit per clock. A registered result with a done pulse frees the bus during long ops.

## Interface
Parameters:
- WIDTH, 32, operand width; even, ≥ 4, power of two
- SHW, $clog2(WIDTH), width of the shift/rotate amount field (derived; not overridden)

Ports:
- clock  in  1  single clock, rising edge
- clear  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only when not busy
- op  in  4  opcode: AND 0000, OR 0001, NEG 0010, NOT 0011, ADD 0100, SUB 0101, MUL 0110, DIV 0111, SHR 1000, SHRA 1001, SHL 1010, ROR 1011, ROL 1100
- a  in  WIDTH  operand Y (unary-op source, dividend, shifted value)
- b  in  WIDTH  bus operand (divisor, shift amount)
- busy  out  1  iterative op in progress
- done  out  1  one-cycle pulse: result valid and updated
- result  out  2*WIDTH  {high, low}; holds until next done
- div_by_zero  out  1  set with done for DIV with b == 0; cleared at next accepted start

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE + start:
  - Latch op, a, b.
  - Single-cycle op: write result, pulse done, stay in IDLE.
  - MUL: go to MUL.
  - DIV with b ≠ 0: go to DIV.
  - DIV with b == 0: single-cycle completion.
- MUL: WIDTH Booth iterations on a (multiplicand) × b (multiplier), 2*WIDTH-bit signed product → IDLE, done.
- DIV: WIDTH non-restoring iterations on |a| / |b| → FIX.
- FIX: final remainder restore plus sign correction → IDLE, done.
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
- Packing:
  - MUL: result = full product.
  - DIV: high = remainder, low = quotient.
  - All other ops: high = 0.
- Arithmetic: ADD/SUB wrap mod 2^WIDTH; no flags. NEG = two's complement of a. NOT = ~a.
- Shifts/rotates: amount = b[SHW-1:0] (i.e. b mod WIDTH), upper bits of b ignored. SHRA sign-fills.
- DIV by zero: low = all ones, high = a, div_by_zero = 1.
- Opcodes 1101–1111: result = 0, done pulses, no error flag.
- start while busy: ignored. No queueing, latched operands unchanged.
- Input changes after acceptance have no effect.

## Timing
- Start accepted at edge k. done is high in the cycle following edge k+L, where:
  - L = 1: logic/shift/add ops, DIV by zero, illegal opcodes
  - L = WIDTH+1: MUL
  - L = WIDTH+2: DIV
- busy is high from edge k+1 to edge k+L; it is low in the done cycle.
- A new start may be accepted in the done cycle (back-to-back).
- clear, at any time including mid-operation, forces:
  - state = IDLE
  - busy = 0, done = 0, div_by_zero = 0
  - result = 0
  - all iteration counters and internal registers = 0
- First start is accepted on the first edge after clear deasserts.
- result changes only on done edges or on clear.

## Structure
- Shared package alu_pkg: opcode localparams (4-bit), FSM state encoding, operation-class helper (single/mul/div).
- Sub-module alu_muldiv_core owns the iterative datapath:
  - Booth multiplier and non-restoring divider share one WIDTH-bit adder/subtractor, the accumulator/remainder register, the iteration counter, and the sign-correction logic.
  - The top level holds the FSM, handshake, single-cycle ops and result register.

## Test plan
WIDTH=32 unless stated:
- ADD a=0x7FFFFFFF, b=1 → result 0x00000000_80000000, done at L=1, busy never high.
- MUL a=-3, b=5 → result 0xFFFFFFFF_FFFFFFF1, done exactly 33 cycles after start, busy high 32 cycles; a start pulse at cycle 10 is ignored.
- DIV a=-7, b=2 → high 0xFFFFFFFF (rem -1), low 0xFFFFFFFD (quot -3), L=34; then DIV a=7, b=0 → low 0xFFFFFFFF, high 0x00000007, div_by_zero=1, L=1.
- ROL a=0x80000001, b=33 → low 0x00000003; SHRA a=0x80000000, b=4 → low 0xF8000000; op=1110 → result 0.
- clear asserted at cycle 15 of a MUL → all outputs 0 immediately (asynchronous); next ADD 2+2 → low 4 with L=1.
- WIDTH=8: MUL -128 × -128 → 0x4000, L=9; DIV 100/7 → high 2, low 14, L=10.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode map, FSM states and op classification.
// No logic of its own; imported by the top and the iterative core.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_NEG  = 4'b0010;
    localparam logic [3:0] OP_NOT  = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0101;
    localparam logic [3:0] OP_MUL  = 4'b0110;
    localparam logic [3:0] OP_DIV  = 4'b0111;
    localparam logic [3:0] OP_SHR  = 4'b1000;
    localparam logic [3:0] OP_SHRA = 4'b1001;
    localparam logic [3:0] OP_SHL  = 4'b1010;
    localparam logic [3:0] OP_ROR  = 4'b1011;
    localparam logic [3:0] OP_ROL  = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CLS_SINGLE = 2'd0,
        CLS_MUL    = 2'd1,
        CLS_DIV    = 2'd2
    } op_class_t;

    function automatic op_class_t op_class(input logic [3:0] op);
        case (op)
            OP_MUL:  return CLS_MUL;
            OP_DIV:  return CLS_DIV;
            default: return CLS_SINGLE;
        endcase
    endfunction

endpackage

// File: rtl/alu_muldiv_core.sv
// Iterative datapath: radix-2 Booth multiply and non-restoring divide, one bit per clock,
// sharing one adder, the accumulator/remainder, the iteration counter and sign fix-up.
module alu_muldiv_core
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 load_mul_i,
    input  logic                 load_div_i,
    input  logic                 step_mul_i,
    input  logic                 step_div_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 last_o,
    output logic [2*WIDTH-1:0]   prod_o,
    output logic [2*WIDTH-1:0]   div_res_o
);

    // acc carries one extra bit: Booth needs it when the multiplicand is the most
    // negative value, and the divider's shifted partial remainder spans +/-2^WIDTH.
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic             qm1_q, qm1_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;

    logic [WIDTH:0]   add_a, add_b, sum;
    logic             add_sub;
    logic [1:0]       pair;
    logic [WIDTH-1:0] rem_mag;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    assign pair = {q_q[0], qm1_q};

    always_comb begin
        add_a   = acc_q;
        add_b   = {1'b0, m_q};
        add_sub = 1'b0;
        if (step_div_i) begin
            add_a   = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
            add_sub = ~acc_q[WIDTH];
        end else if (step_mul_i) begin
            add_b   = (pair == 2'b01 || pair == 2'b10) ? {m_q[WIDTH-1], m_q} : '0;
            add_sub = (pair == 2'b10);
        end
        sum = add_a + (add_sub ? ~add_b : add_b) + {{WIDTH{1'b0}}, add_sub};
    end

    assign last_o  = (cnt_q == SHW'(WIDTH - 1));
    // Product after the step currently in flight: {acc, q} shifted right by one.
    assign prod_o  = {sum, q_q[WIDTH-1:1]};
    // Outside a step the adder restores a negative remainder (acc + divisor).
    assign rem_mag = acc_q[WIDTH] ? sum[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign div_res_o = {cond_neg(rem_mag, rneg_q), cond_neg(q_q, qneg_q)};

    always_comb begin
        acc_d  = acc_q;
        q_d    = q_q;
        m_d    = m_q;
        qm1_d  = qm1_q;
        cnt_d  = cnt_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        if (load_mul_i) begin
            acc_d  = '0;
            q_d    = b_i;
            m_d    = a_i;
            qm1_d  = 1'b0;
            cnt_d  = '0;
            qneg_d = 1'b0;
            rneg_d = 1'b0;
        end else if (load_div_i) begin
            acc_d  = '0;
            q_d    = cond_neg(a_i, a_i[WIDTH-1]);
            m_d    = cond_neg(b_i, b_i[WIDTH-1]);
            qm1_d  = 1'b0;
            cnt_d  = '0;
            qneg_d = a_i[WIDTH-1] ^ b_i[WIDTH-1];
            rneg_d = a_i[WIDTH-1];
        end else if (step_mul_i) begin
            acc_d = {sum[WIDTH], sum[WIDTH:1]};
            q_d   = {sum[0], q_q[WIDTH-1:1]};
            qm1_d = q_q[0];
            cnt_d = cnt_q + SHW'(1);
        end else if (step_div_i) begin
            acc_d = sum;
            q_d   = {q_q[WIDTH-2:0], ~sum[WIDTH]};
            cnt_d = cnt_q + SHW'(1);
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            acc_q  <= '0;
            q_q    <= '0;
            m_q    <= '0;
            qm1_q  <= 1'b0;
            cnt_q  <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            q_q    <= q_d;
            m_q    <= m_d;
            qm1_q  <= qm1_d;
            cnt_q  <= cnt_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: 1-cycle logic/shift/add, WIDTH+1 MUL, WIDTH+2 DIV; registered result with done pulse.
// start is only sampled in IDLE; requests arriving while busy are dropped, not queued.
module seq_alu
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 start,
    input  logic [3:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 div_by_zero
);

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 done_q, done_d;
    logic                 dbz_q, dbz_d;

    logic                 load_mul, load_div, step_mul, step_div;
    logic                 last;
    logic [2*WIDTH-1:0]   prod, div_res;

    function automatic logic [WIDTH-1:0] single_op(input logic [3:0] o,
                                                   input logic [WIDTH-1:0] x,
                                                   input logic [WIDTH-1:0] y);
        logic [SHW-1:0]     amt;
        logic [2*WIDTH-1:0] dbl, rr, rl;
        amt = y[SHW-1:0];
        dbl = {x, x};
        rr  = dbl >> amt;
        rl  = dbl << amt;
        case (o)
            OP_AND:  return x & y;
            OP_OR:   return x | y;
            OP_NEG:  return ~x + WIDTH'(1);
            OP_NOT:  return ~x;
            OP_ADD:  return x + y;
            OP_SUB:  return x - y;
            OP_SHR:  return x >> amt;
            OP_SHRA: return $signed(x) >>> amt;
            OP_SHL:  return x << amt;
            OP_ROR:  return rr[WIDTH-1:0];
            OP_ROL:  return rl[2*WIDTH-1:WIDTH];
            default: return '0;
        endcase
    endfunction

    alu_muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clock      (clock),
        .clear      (clear),
        .load_mul_i (load_mul),
        .load_div_i (load_div),
        .step_mul_i (step_mul),
        .step_div_i (step_div),
        .a_i        (a),
        .b_i        (b),
        .last_o     (last),
        .prod_o     (prod),
        .div_res_o  (div_res)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        done_d   = 1'b0;
        dbz_d    = dbz_q;
        load_mul = 1'b0;
        load_div = 1'b0;
        step_mul = 1'b0;
        step_div = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dbz_d = 1'b0;
                    case (op_class(op))
                        CLS_MUL: begin
                            load_mul = 1'b1;
                            state_d  = ST_MUL;
                        end
                        CLS_DIV: begin
                            if (b != '0) begin
                                load_div = 1'b1;
                                state_d  = ST_DIV;
                            end else begin
                                result_d = {a, {WIDTH{1'b1}}};
                                done_d   = 1'b1;
                                dbz_d    = 1'b1;
                            end
                        end
                        default: begin
                            result_d = {{WIDTH{1'b0}}, single_op(op, a, b)};
                            done_d   = 1'b1;
                        end
                    endcase
                end
            end
            ST_MUL: begin
                step_mul = 1'b1;
                if (last) begin
                    result_d = prod;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_DIV: begin
                step_div = 1'b1;
                if (last) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                result_d = div_res;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign result      = result_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboarded random + directed bench for seq_alu at WIDTH=32 and WIDTH=8.
module tb_seq_alu;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        start32 = 1'b0, start8 = 1'b0;
    logic [3:0]  op32 = '0, op8 = '0;
    logic [31:0] a32 = '0, b32 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy32, done32, dbz32, busy8, done8, dbz8;
    logic [63:0] res32;
    logic [15:0] res8;

    int cyc = 0, errors = 0, checks = 0, bcnt32 = 0, bcnt8 = 0;

    typedef struct {
        logic [63:0] res;
        logic        dbz;
        int          lat;
        int          issue;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];

    seq_alu #(.WIDTH(32)) dut32 (
        .clock(clock), .clear(clear), .start(start32), .op(op32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .result(res32), .div_by_zero(dbz32)
    );

    seq_alu #(.WIDTH(8)) dut8 (
        .clock(clock), .clear(clear), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(res8), .div_by_zero(dbz8)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference behaviour from the arithmetic definition, using 64-bit integers.
    function automatic exp_t model(input int w, input logic [3:0] o,
                                   input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        longint      mask, ua, ub, sa, sb, amt;
        logic [63:0] m2;
        mask = (longint'(1) << w) - 1;
        m2   = {64{1'b1}} >> (64 - 2 * w);
        ua   = longint'({32'h0, x}) & mask;
        ub   = longint'({32'h0, y}) & mask;
        sa   = (ua > mask / 2) ? ua - (mask + 1) : ua;
        sb   = (ub > mask / 2) ? ub - (mask + 1) : ub;
        amt  = ub % w;
        e.res = '0; e.dbz = 1'b0; e.lat = 1; e.issue = 0;
        case (o)
            4'd0:  e.res = ua & ub;
            4'd1:  e.res = ua | ub;
            4'd2:  e.res = (-ua) & mask;
            4'd3:  e.res = (~ua) & mask;
            4'd4:  e.res = (ua + ub) & mask;
            4'd5:  e.res = (ua - ub) & mask;
            4'd6:  begin e.res = (sa * sb) & m2; e.lat = w + 1; end
            4'd7:  begin
                if (ub == 0) begin
                    e.res = (ua << w) | mask;
                    e.dbz = 1'b1;
                end else begin
                    e.res = (((sa % sb) & mask) << w) | ((sa / sb) & mask);
                    e.lat = w + 2;
                end
            end
            4'd8:  e.res = ua >> amt;
            4'd9:  e.res = (sa >>> amt) & mask;
            4'd10: e.res = (ua << amt) & mask;
            4'd11: e.res = ((ua >> amt) | (ua << (w - amt))) & mask;
            4'd12: e.res = ((ua << amt) | (ua >> (w - amt))) & mask;
            default: e.res = '0;
        endcase
        return e;
    endfunction

    task automatic on_done(input bit w8, input logic [63:0] res, input logic dbz, input int bcnt);
        exp_t e;
        if ((w8 && q8.size() == 0) || (!w8 && q32.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL spurious_done_w%0d: got done with result %h, expected no done", w8 ? 8 : 32, res);
            return;
        end
        if (w8) e = q8.pop_front();
        else    e = q32.pop_front();
        check(w8 ? "result_w8" : "result_w32", res, e.res);
        check("div_by_zero", {63'h0, dbz}, {63'h0, e.dbz});
        check("latency", 64'(cyc - e.issue), 64'(e.lat));
        check("busy_cycles", 64'(bcnt), 64'(e.lat - 1));
    endtask

    // Monitor: pops the scoreboard whenever a DUT presents done.
    initial forever begin
        @(negedge clock);
        if (clear) begin
            bcnt32 = 0;
            bcnt8  = 0;
        end else begin
            if (done32) begin
                check("busy_low_at_done_w32", {63'h0, busy32}, 64'h0);
                on_done(1'b0, res32, dbz32, bcnt32);
                bcnt32 = 0;
            end else if (busy32) begin
                bcnt32++;
            end
            if (done8) begin
                on_done(1'b1, {48'h0, res8}, dbz8, bcnt8);
                bcnt8 = 0;
            end else if (busy8) begin
                bcnt8++;
            end
        end
    end

    // Issue one request at the current negedge, scramble inputs after acceptance,
    // optionally pulse an extra start 'poke' cycles in, and return in the done cycle.
    task automatic send(input bit w8, input logic [3:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int poke);
        exp_t e;
        int   n;
        e = model(w8 ? 8 : 32, o, x, y);
        e.issue = cyc;
        if (w8) begin
            op8 = o; a8 = x[7:0]; b8 = y[7:0]; start8 = 1'b1;
            q8.push_back(e);
        end else begin
            op32 = o; a32 = x; b32 = y; start32 = 1'b1;
            q32.push_back(e);
        end
        @(negedge clock);
        start8 = 1'b0; start32 = 1'b0;
        op32 = 4'($urandom); a32 = $urandom; b32 = $urandom;
        op8 = 4'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
        n = 0;
        while (!(w8 ? done8 : done32) && n < 200) begin
            if (poke > 0 && n == poke) begin
                if (w8) begin op8 = 4'h4; start8 = 1'b1; end
                else    begin op32 = 4'h4; start32 = 1'b1; end
            end
            @(negedge clock);
            start8 = 1'b0; start32 = 1'b0;
            n++;
        end
        if (!(w8 ? done8 : done32)) begin
            checks++;
            errors++;
            $display("FAIL timeout_op%0h: got no done within %0d cycles, expected done", o, n);
        end
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 40));
            4:       return 32'h0000_0080;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        repeat (3) @(negedge clock);
        check("reset_busy", {63'h0, busy32}, 64'h0);
        check("reset_done", {63'h0, done32}, 64'h0);
        check("reset_result", res32, 64'h0);
        check("reset_dbz", {63'h0, dbz32}, 64'h0);
        check("reset_result_w8", {48'h0, res8}, 64'h0);
        clear = 1'b0;

        // Directed WIDTH=32 cases
        send(1'b0, 4'h4, 32'h7FFF_FFFF, 32'h1, 0);
        send(1'b0, 4'h6, -32'sd3, 32'd5, 10);
        send(1'b0, 4'h7, -32'sd7, 32'd2, 0);
        send(1'b0, 4'h7, 32'd7, 32'd0, 0);
        send(1'b0, 4'hC, 32'h8000_0001, 32'd33, 0);
        send(1'b0, 4'h9, 32'h8000_0000, 32'd4, 0);
        send(1'b0, 4'hE, 32'h1234_5678, 32'h9ABC_DEF0, 0);
        send(1'b0, 4'h6, 32'h8000_0000, 32'h8000_0000, 0);
        send(1'b0, 4'h7, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        send(1'b0, 4'h7, 32'd7, -32'sd2, 0);
        send(1'b0, 4'hB, 32'h0000_00F1, 32'h0000_0024, 0);

        // Asynchronous clear in the middle of a multiply
        op32 = 4'h6; a32 = 32'd1234; b32 = -32'sd77; start32 = 1'b1;
        @(negedge clock);
        start32 = 1'b0;
        repeat (14) @(negedge clock);
        #1 clear = 1'b1;
        #1;
        check("clear_busy", {63'h0, busy32}, 64'h0);
        check("clear_done", {63'h0, done32}, 64'h0);
        check("clear_result", res32, 64'h0);
        check("clear_dbz", {63'h0, dbz32}, 64'h0);
        repeat (2) @(negedge clock);
        clear = 1'b0;
        send(1'b0, 4'h4, 32'd2, 32'd2, 0);

        for (int i = 0; i < 120; i++) begin
            send(1'b0, 4'($urandom_range(0, 15)), rnd_operand(), rnd_operand(), 0);
        end

        // Directed and random WIDTH=8 cases
        send(1'b1, 4'h6, 32'h80, 32'h80, 0);
        send(1'b1, 4'h7, 32'd100, 32'd7, 0);
        send(1'b1, 4'h7, 32'h80, 32'hFF, 0);
        for (int i = 0; i < 60; i++) begin
            send(1'b1, 4'($urandom_range(0, 15)), rnd_operand(), rnd_operand(), 0);
        end

        repeat (5) @(negedge clock);
        check("scoreboard_empty_w32", 64'(q32.size()), 64'h0);
        check("scoreboard_empty_w8", 64'(q8.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
